// File: rtl/wb_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_port_arbiter_if
// Bus bundle for the register-file write-port arbiter: pipeline write-back,
// long-latency result delivery, decode hazard query and the merged
// register-file write port.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface wb_port_arbiter_if;
  logic        wb_rf_wena;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        raw_hazard;
  logic        stall_req;
  logic        rf_wena;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fifo_empty;

  // Arbiter side
  modport slave (
    input  wb_rf_wena, wb_rf_waddr, wb_rf_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    input  id_rs, id_rt,
    output lu_ready, raw_hazard, stall_req,
    output rf_wena, rf_waddr, rf_wdata, fifo_empty
  );

  // Pipeline / long-latency unit / register-file side
  modport master (
    output wb_rf_wena, wb_rf_waddr, wb_rf_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    output id_rs, id_rt,
    input  lu_ready, raw_hazard, stall_req,
    input  rf_wena, rf_waddr, rf_wdata, fifo_empty
  );
endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the register-file write port between the in-order write-back stage
// and an out-of-band long-latency unit. Late results wait in a small FIFO,
// drain into idle port slots, are cancelled when a younger pipeline write
// hits the same register, and a starving head forces a one-cycle freeze.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic           clk,
  input  logic           rst,
  wb_port_arbiter_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  // FIFO state: live bits reset, payload storage does not need to
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];

  // Starvation tracking
  logic [WW-1:0]    wait_q, wait_d;
  logic             stall_q, stall_d;

  logic             pipe_busy;
  logic             not_empty;
  logic             head_live;
  logic             grant_head;
  logic             pop;
  logic             accept;
  logic             enq;
  logic             blocked;
  logic [DEPTH-1:0] cancel;
  logic             hazard;
  logic             lu_ready;

  assign lu_ready = ~rst & (count_q < CW'(DEPTH));

  // Port arbitration, pop/enqueue decisions, cancellation and hazard detection
  always_comb begin
    pipe_busy  = bus.wb_rf_wena & (bus.wb_rf_waddr != 5'd0) & ~stall_q;
    not_empty  = (count_q != '0);
    head_live  = not_empty & live_q[head_q];
    grant_head = head_live & ~pipe_busy;
    // A dead head leaves regardless; a live head leaves only when it wins the port
    pop        = not_empty & (~live_q[head_q] | ~pipe_busy);
    blocked    = head_live & pipe_busy;
    accept     = bus.lu_valid & lu_ready;
    enq        = accept & (bus.lu_waddr != 5'd0);

    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cancel[i] = pipe_busy & live_q[i] & (addr_q[i] == bus.wb_rf_waddr);
      if (live_q[i] & ~cancel[i] &
          (((bus.id_rs != 5'd0) & (bus.id_rs == addr_q[i])) |
           ((bus.id_rt != 5'd0) & (bus.id_rt == addr_q[i]))))
        hazard = 1'b1;
    end
    if (accept &
        (((bus.id_rs != 5'd0) & (bus.id_rs == bus.lu_waddr)) |
         ((bus.id_rt != 5'd0) & (bus.id_rt == bus.lu_waddr))))
      hazard = 1'b1;
  end

  // Next-state for FIFO pointers, live bits and the starvation counter
  always_comb begin
    count_d = count_q + CW'(enq) - CW'(pop);
    head_d  = pop ? head_q + PW'(1) : head_q;
    tail_d  = enq ? tail_q + PW'(1) : tail_q;

    // Popped slots go dead so free slots never look live; a same-cycle
    // enqueue lands in a free slot and wins over any cancel
    live_d = live_q & ~cancel;
    if (pop) live_d[head_q] = 1'b0;
    if (enq) live_d[tail_q] = 1'b1;

    stall_d = 1'b0;
    wait_d  = wait_q;
    if (pop || !not_empty) begin
      wait_d = '0;
    end else if (blocked) begin
      if (wait_q == WW'(MAX_WAIT - 1)) begin
        stall_d = 1'b1;
        wait_d  = '0;
      end else begin
        wait_d = wait_q + WW'(1);
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      live_q  <= '0;
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      live_q  <= live_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  // Payload storage written at the tail on enqueue
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= bus.lu_waddr;
      data_q[tail_q] <= bus.lu_wdata;
    end
  end

  assign bus.lu_ready   = lu_ready;
  assign bus.raw_hazard = hazard;
  assign bus.stall_req  = stall_q;
  assign bus.fifo_empty = (count_q == '0);
  assign bus.rf_wena    = ~rst & (grant_head | bus.wb_rf_wena);
  assign bus.rf_waddr   = grant_head ? addr_q[head_q] : bus.wb_rf_waddr;
  assign bus.rf_wdata   = grant_head ? data_q[head_q] : bus.wb_rf_wdata;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Self-checking bench: directed vector table, hand sequences for starvation,
// cancellation and mid-run reset, then randomized traffic against a
// queue-based reference model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_wb_port_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: ordered list of buffered results
  typedef struct {
    bit          live;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];
  int   m_wait  = 0;
  bit   m_stall = 1'b0;

  // Model predictions and sampled DUT outputs
  logic        e_ready, e_haz, e_stall, e_wena, e_empty;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  logic        a_ready, a_haz, a_stall, a_wena, a_empty;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;

  typedef struct {
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        luv;
    logic [4:0]  lua;
    logic [31:0] lud;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        x_ready;
    logic        x_haz;
    logic        x_wena;
    logic [4:0]  x_waddr;
    logic [31:0] x_wdata;
    logic        x_empty;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic wena, input logic [4:0] waddr, input logic [31:0] wdata,
                        input logic luv, input logic [4:0] lua, input logic [31:0] lud,
                        input logic [4:0] rs, input logic [4:0] rt);
    bus.wb_rf_wena  = wena;
    bus.wb_rf_waddr = waddr;
    bus.wb_rf_wdata = wdata;
    bus.lu_valid    = luv;
    bus.lu_waddr    = lua;
    bus.lu_wdata    = lud;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
  endtask

  function automatic bit src_hit(input logic [4:0] a, input logic [4:0] rs, input logic [4:0] rt);
    return ((rs != 5'd0) && (rs == a)) || ((rt != 5'd0) && (rt == a));
  endfunction

  task automatic model_eval();
    bit busy;
    bit hl;
    busy    = bus.wb_rf_wena && (bus.wb_rf_waddr != 5'd0) && !m_stall;
    hl      = (mq.size() > 0) && mq[0].live;
    e_ready = (mq.size() < DEPTH);
    e_stall = m_stall;
    e_empty = (mq.size() == 0);
    if (!busy && hl) begin
      e_wena  = 1'b1;
      e_waddr = mq[0].addr;
      e_wdata = mq[0].data;
    end else begin
      e_wena  = bus.wb_rf_wena;
      e_waddr = bus.wb_rf_waddr;
      e_wdata = bus.wb_rf_wdata;
    end
    e_haz = 1'b0;
    foreach (mq[i])
      if (mq[i].live && !(busy && mq[i].addr == bus.wb_rf_waddr) &&
          src_hit(mq[i].addr, bus.id_rs, bus.id_rt))
        e_haz = 1'b1;
    if (bus.lu_valid && e_ready && src_hit(bus.lu_waddr, bus.id_rs, bus.id_rt))
      e_haz = 1'b1;
  endtask

  task automatic model_advance();
    bit   busy, popped, blocked, accept, nstall;
    ent_t ne;
    busy    = bus.wb_rf_wena && (bus.wb_rf_waddr != 5'd0) && !m_stall;
    accept  = bus.lu_valid && (mq.size() < DEPTH);
    popped  = 1'b0;
    blocked = 1'b0;
    if (mq.size() > 0) begin
      if (mq[0].live && busy) blocked = 1'b1;
      else                    popped  = 1'b1;
    end
    nstall = 1'b0;
    if (popped || mq.size() == 0) m_wait = 0;
    else if (blocked) begin
      if (m_wait == MAX_WAIT - 1) begin
        nstall = 1'b1;
        m_wait = 0;
      end else begin
        m_wait++;
      end
    end
    if (busy)
      foreach (mq[i])
        if (mq[i].addr == bus.wb_rf_waddr) mq[i].live = 1'b0;
    if (popped) mq.delete(0);
    if (accept && bus.lu_waddr != 5'd0) begin
      ne.live = 1'b1;
      ne.addr = bus.lu_waddr;
      ne.data = bus.lu_wdata;
      mq.push_back(ne);
    end
    m_stall = nstall;
  endtask

  task automatic model_reset();
    mq.delete();
    m_wait  = 0;
    m_stall = 1'b0;
  endtask

  // One clock cycle: sample at negedge, compare with model, advance past posedge
  task automatic step();
    @(negedge clk);
    model_eval();
    a_ready = bus.lu_ready;
    a_haz   = bus.raw_hazard;
    a_stall = bus.stall_req;
    a_wena  = bus.rf_wena;
    a_waddr = bus.rf_waddr;
    a_wdata = bus.rf_wdata;
    a_empty = bus.fifo_empty;
    chk("m_lu_ready",   {31'd0, a_ready}, {31'd0, e_ready});
    chk("m_raw_hazard", {31'd0, a_haz},   {31'd0, e_haz});
    chk("m_stall_req",  {31'd0, a_stall}, {31'd0, e_stall});
    chk("m_rf_wena",    {31'd0, a_wena},  {31'd0, e_wena});
    chk("m_rf_waddr",   {27'd0, a_waddr}, {27'd0, e_waddr});
    chk("m_rf_wdata",   a_wdata,          e_wdata);
    chk("m_fifo_empty", {31'd0, a_empty}, {31'd0, e_empty});
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  initial begin
    // Directed table, applied straight after reset
    tbl[0] = '{1'b0, 5'd0, 32'h0,   1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1};
    tbl[1] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1};
    tbl[3] = '{1'b1, 5'd3, 32'h33,  1'b1, 5'd4, 32'h44,       5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33,       1'b1};
    tbl[4] = '{1'b1, 5'd3, 32'h34,  1'b0, 5'd0, 32'h0,        5'd4, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h34,       1'b0};
    tbl[5] = '{1'b1, 5'd3, 32'h35,  1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h35,       1'b0};
    tbl[6] = '{1'b1, 5'd3, 32'h36,  1'b1, 5'd6, 32'h66,       5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 5'd3, 32'h36,       1'b0};
    tbl[7] = '{1'b0, 5'd0, 32'h0,   1'b1, 5'd0, 32'hBAD,      5'd6, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44,       1'b0};
    tbl[8] = '{1'b0, 5'd0, 32'h0,   1'b1, 5'd0, 32'hBAD,      5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h66,       1'b0};
    tbl[9] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1};

    // Reset with the pipeline trying to write: port must stay quiet
    rst = 1'b1;
    set_in(1'b1, 5'd3, 32'h333, 1'b1, 5'd7, 32'h7, 5'd0, 5'd0);
    @(negedge clk);
    chk("rst_rf_wena",    {31'd0, bus.rf_wena},    32'd0);
    chk("rst_lu_ready",   {31'd0, bus.lu_ready},   32'd0);
    chk("rst_stall_req",  {31'd0, bus.stall_req},  32'd0);
    chk("rst_fifo_empty", {31'd0, bus.fifo_empty}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].wena, tbl[i].waddr, tbl[i].wdata, tbl[i].luv, tbl[i].lua, tbl[i].lud,
             tbl[i].rs, tbl[i].rt);
      step();
      chk($sformatf("v%0d_lu_ready", i),   {31'd0, a_ready}, {31'd0, tbl[i].x_ready});
      chk($sformatf("v%0d_raw_hazard", i), {31'd0, a_haz},   {31'd0, tbl[i].x_haz});
      chk($sformatf("v%0d_rf_wena", i),    {31'd0, a_wena},  {31'd0, tbl[i].x_wena});
      chk($sformatf("v%0d_rf_waddr", i),   {27'd0, a_waddr}, {27'd0, tbl[i].x_waddr});
      chk($sformatf("v%0d_rf_wdata", i),   a_wdata,          tbl[i].x_wdata);
      chk($sformatf("v%0d_fifo_empty", i), {31'd0, a_empty}, {31'd0, tbl[i].x_empty});
    end

    // Starvation: busy r3 every cycle, r7 then r8 buffered, third push refused
    set_in(1'b1, 5'd3, 32'h300, 1'b1, 5'd7,  32'h77, 5'd0, 5'd0); step();
    set_in(1'b1, 5'd3, 32'h301, 1'b1, 5'd8,  32'h88, 5'd0, 5'd0); step();
    set_in(1'b1, 5'd3, 32'h302, 1'b1, 5'd10, 32'hAA, 5'd0, 5'd0); step();
    chk("starve_full_ready", {31'd0, a_ready}, 32'd0);
    for (int c = 3; c <= 8; c++) begin
      set_in(1'b1, 5'd3, 32'h300 + c, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step();
      chk($sformatf("starve_c%0d_nostall", c), {31'd0, a_stall}, 32'd0);
    end
    set_in(1'b1, 5'd3, 32'h309, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step();
    chk("starve_stall",      {31'd0, a_stall}, 32'd1);
    chk("starve_head_addr",  {27'd0, a_waddr}, 32'd7);
    chk("starve_head_data",  a_wdata,          32'h77);
    set_in(1'b1, 5'd3, 32'h309, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step();
    chk("starve_one_cycle",  {31'd0, a_stall}, 32'd0);
    chk("starve_r3_wena",    {31'd0, a_wena},  32'd1);
    chk("starve_r3_addr",    {27'd0, a_waddr}, 32'd3);
    idle(); step();
    chk("starve_r8_addr",    {27'd0, a_waddr}, 32'd8);
    chk("starve_r8_data",    a_wdata,          32'h88);
    idle(); step();
    chk("starve_drained",    {31'd0, a_empty}, 32'd1);

    // Cancellation by a younger pipeline write to the same register
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0); step();
    set_in(1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0); step();
    chk("cancel_pipe_addr",  {27'd0, a_waddr}, 32'd9);
    chk("cancel_pipe_data",  a_wdata,          32'h11);
    chk("cancel_no_hazard",  {31'd0, a_haz},   32'd0);
    idle(); step();
    chk("cancel_dead_nowr",  {31'd0, a_wena},  32'd0);
    chk("cancel_dead_held",  {31'd0, a_empty}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      idle(); step();
      chk($sformatf("cancel_empty_%0d", c), {31'd0, a_empty}, 32'd1);
      chk($sformatf("cancel_nowr_%0d", c),  {31'd0, a_wena},  32'd0);
    end

    // Mid-run reset with two entries buffered and the head blocked 5 cycles
    set_in(1'b1, 5'd3, 32'h400, 1'b1, 5'd12, 32'hC0, 5'd0, 5'd0); step();
    set_in(1'b1, 5'd3, 32'h401, 1'b1, 5'd13, 32'hD0, 5'd0, 5'd0); step();
    for (int c = 2; c <= 5; c++) begin
      set_in(1'b1, 5'd3, 32'h400 + c, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step();
    end
    set_in(1'b1, 5'd3, 32'h406, 1'b1, 5'd14, 32'hE0, 5'd0, 5'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_rf_wena",   {31'd0, bus.rf_wena},    32'd0);
    chk("mrst_lu_ready",  {31'd0, bus.lu_ready},   32'd0);
    chk("mrst_stall_req", {31'd0, bus.stall_req},  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      idle(); step();
      chk($sformatf("mrst_empty_%0d", c), {31'd0, a_empty}, 32'd1);
      chk($sformatf("mrst_nowr_%0d", c),  {31'd0, a_wena},  32'd0);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)),
             $urandom,
             1'($urandom_range(0, 9) < 4),
             5'($urandom_range(0, 7)),
             $urandom,
             5'($urandom_range(0, 9)),
             5'($urandom_range(0, 9)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline write-back stage and a long-latency execution unit (multiply/divide result path) that delivers results out of band.
- Late results are buffered in a small FIFO.
- Buffered results drain into write-port slots the pipeline leaves idle.
- Buffered results that a younger pipeline write has superseded are cancelled.
- The block reports RAW hazards against pending results to decode.
- It forces a one-cycle pipeline freeze if a buffered result starves.

Parameters:
DEPTH, 2, number of buffered long-latency results (power of two, >=2)
MAX_WAIT, 8, consecutive blocked cycles of a live FIFO head before a freeze is requested (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
wb_rf_wena  input  1  pipeline WB write enable
wb_rf_waddr  input  5  pipeline WB destination register
wb_rf_wdata  input  32  pipeline WB write data
lu_valid  input  1  long-latency unit result valid
lu_waddr  input  5  long-latency result destination
lu_wdata  input  32  long-latency result data
lu_ready  output  1  arbiter can accept a result this cycle
id_rs  input  5  decode source register 1
id_rt  input  5  decode source register 2
raw_hazard  output  1  decode source matches a pending live result
stall_req  output  1  freeze pipeline WB and upstream this cycle (registered)
rf_wena  output  1  register-file write enable
rf_waddr  output  5  register-file write address
rf_wdata  output  32  register-file write data
fifo_empty  output  1  no entries buffered (live or dead)

Behaviour:
- Reset: clk and rst as named; rst is asynchronous and active-high.
  - On reset, count=0, all entry live bits=0, wait_cnt=0, stall_req=0.
  - While rst=1, rf_wena=0 and lu_ready=0.
- pipe_busy = wb_rf_wena & (wb_rf_waddr!=0) & ~stall_req.
- Enqueue:
  - lu_ready = (count<DEPTH). It depends on count only; a pop in the same cycle does not free a slot.
  - On lu_valid & lu_ready: if lu_waddr!=0, write {live=1, addr, data} at the tail.
  - If lu_waddr==0, the result is accepted and discarded.
  - A result accepted in cycle N can reach the port no earlier than cycle N+1; there is no bypass.
- Port select (combinational):
  - If pipe_busy, the outputs pass the pipeline WB values.
  - Else if the head is live, rf_wena=1 and rf_waddr/rf_wdata come from the head, and the head pops at the edge.
  - Else the outputs pass the pipeline values unchanged (a wena=0 or r0 write is harmless).
- Dead-head pop: if the head is not live, it pops at the edge regardless of pipe_busy and writes nothing.
- At most one pop per cycle; count updates as +enq-pop.
- Cancel:
  - When pipe_busy, every live entry already in the FIFO with addr==wb_rf_waddr has its live bit cleared at the edge. The younger pipeline write supersedes it.
  - An entry enqueued in the same cycle is never cancelled.
- raw_hazard is combinational. It is 1 if id_rs!=0 or id_rt!=0 matches either of:
  - the addr of any live entry not being cancelled this cycle, or
  - the incoming lu_waddr when lu_valid & lu_ready.
- Starvation:
  - wait_cnt increments when the head is live and pipe_busy.
  - It clears when the head pops or the FIFO is empty.
  - When wait_cnt==MAX_WAIT-1 and the head is still blocked, stall_req=1 on the next cycle for exactly one cycle, and wait_cnt clears.
  - During stall_req=1, the pipeline holds its WB registers and re-presents the same write next cycle. The arbiter ignores the WB write (no cancel) and gives the port to the live head.
  - stall_req never asserts on consecutive cycles.
- Mid-operation reset: buffered results are lost; the long-latency unit is reset by the same rst.
- fifo_empty = (count==0).

Test Plan:
- Idle pipeline (wb_rf_wena=0); lu_valid with addr=5, data=0xDEADBEEF in cycle 0 -> lu_ready=1; rf_wena=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 1; fifo_empty=1 in cycle 2.
- Pipeline busy writing r3 every cycle; push results to r7 and r8 -> the third push sees lu_ready=0; after MAX_WAIT=8 blocked cycles, stall_req=1 for one cycle and r7 is written in that cycle; the r3 write still occurs the following cycle.
- Push r9 result; next cycle pipeline writes r9=0x11 -> the entry is cancelled, no later write to r9 occurs, and fifo_empty=1 after the dead-head pop.
- Pending live r4 entry; id_rs=4 -> raw_hazard=1; id_rs=0 and id_rt=0 -> raw_hazard=0; lu_valid with lu_waddr=6 and id_rt=6 in the same cycle -> raw_hazard=1.
- lu_valid with lu_waddr=0 -> accepted, count unchanged, no write issued.
- Assert rst with 2 entries buffered and wait_cnt=5 -> rf_wena=0, lu_ready=0, stall_req=0 immediately; after release fifo_empty=1 and no stale write appears.
